// File: rtl/fetch_unit_f_pkg.sv
// Shared types and constants for the F-stage fetch unit: word type, reset
// constants, FSM encoding and the PC alignment helper.
package fetch_unit_f_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_PC_DEF = 32'h0000_3000;
  localparam word_t NOP_WORD_DEF = 32'h0000_0000;

  typedef logic [1:0] state_t;

  localparam state_t ST_REQ  = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

  localparam word_t WORD_MASK = 32'hFFFF_FFFC;

  // Redirect targets drop their byte offset so fetches stay word aligned.
  function automatic word_t align_word(input word_t addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_unit_f_if.sv
// Instruction memory request/response bus between the fetch unit (master)
// and the variable-latency instruction memory (slave).
interface fetch_unit_f_if;
  import fetch_unit_f_pkg::*;

  logic  im_req;
  word_t im_addr;
  logic  im_rvalid;
  word_t im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_rvalid,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_rvalid,
    output im_rdata
  );

endinterface

// File: rtl/fetch_unit_f.sv
// F-stage fetch unit: owns the PC, issues one fetch at a time, holds the word
// until D accepts it, and applies D-stage redirects after the delay slot.
module fetch_unit_f
  import fetch_unit_f_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEF,
  parameter word_t NOP_WORD = NOP_WORD_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  D_en,
  input  logic                  redirect_valid,
  input  word_t                 redirect_pc,
  fetch_unit_f_if.master        im,
  output word_t                 IR_F,
  output word_t                 pc4_F,
  output word_t                 pc8_F,
  output logic                  F_valid
);

  state_t state_q, state_d;
  word_t  pc_q, pc_d;
  word_t  ir_buf_q, ir_buf_d;
  logic   pend_valid_q, pend_valid_d;
  word_t  pend_pc_q, pend_pc_d;

  word_t  redirect_tgt;
  word_t  next_pc;
  logic   consume;

  assign redirect_tgt = align_word(redirect_pc);
  assign consume      = (state_q == ST_HOLD) && D_en;

  // A live redirect beats a remembered one, which beats sequential flow.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (redirect_valid) begin
      next_pc = redirect_tgt;
    end else if (pend_valid_q) begin
      next_pc = pend_pc_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_buf_d     = ir_buf_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;

    case (state_q)
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (im.im_rvalid) begin
          ir_buf_d = im.im_rdata;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (D_en) begin
          state_d      = ST_REQ;
          pc_d         = next_pc;
          pend_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase

    // The fetch in flight or held word is the delay slot; remember the target.
    if (redirect_valid && !consume) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = redirect_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      ir_buf_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_buf_q     <= ir_buf_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  assign im.im_req  = (state_q == ST_REQ);
  assign im.im_addr = pc_q;
  assign F_valid    = (state_q == ST_HOLD);
  assign IR_F       = F_valid ? ir_buf_q : NOP_WORD;
  assign pc4_F      = pc_q + 32'd4;
  assign pc8_F      = pc_q + 32'd8;

endmodule

// File: tb/tb_fetch_unit_f.sv
// Directed bench for fetch_unit_f with a variable-latency instruction memory
// model; every comparison is an immediate assertion.
module tb_fetch_unit_f;
  import fetch_unit_f_pkg::*;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  logic  D_en = 1'b0;
  logic  redirect_valid = 1'b0;
  word_t redirect_pc = '0;
  word_t IR_F, pc4_F, pc8_F;
  logic  F_valid;

  int    passCount = 0;
  int    checkCount = 0;
  int    memLat = 1;
  int    countdown = 0;
  word_t reqAddr = '0;

  fetch_unit_f_if imBus ();

  fetch_unit_f dut (
    .clk            (clk),
    .reset          (reset),
    .D_en           (D_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im             (imBus),
    .IR_F           (IR_F),
    .pc4_F          (pc4_F),
    .pc8_F          (pc8_F),
    .F_valid        (F_valid)
  );

  always #5 clk = ~clk;

  function automatic word_t memWord(input word_t addr);
    if (addr == 32'h0000_3000) return 32'h2409_0001;
    return {16'h8C00, addr[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic nextCycle;
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic rv, input word_t rpc);
    D_en           = en;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic checkReq(input string tag, input word_t expAddr);
    checkOutput({tag, "_req"}, {31'b0, imBus.im_req}, 32'd1);
    checkOutput({tag, "_addr"}, imBus.im_addr, expAddr);
    checkOutput({tag, "_valid"}, {31'b0, F_valid}, 32'd0);
    checkOutput({tag, "_ir"}, IR_F, NOP_WORD_DEF);
  endtask

  task automatic checkHold(input string tag, input word_t expIr, input word_t expPc);
    word_t e4, e8;
    e4 = expPc + 32'd4;
    e8 = expPc + 32'd8;
    checkOutput({tag, "_valid"}, {31'b0, F_valid}, 32'd1);
    checkOutput({tag, "_ir"}, IR_F, expIr);
    checkOutput({tag, "_pc4"}, pc4_F, e4);
    checkOutput({tag, "_pc8"}, pc8_F, e8);
    checkOutput({tag, "_noreq"}, {31'b0, imBus.im_req}, 32'd0);
  endtask

  task automatic waitHold(input string tag, input int budget);
    for (int i = 0; i < budget && F_valid !== 1'b1; i++) nextCycle();
    checkOutput({tag, "_arrived"}, {31'b0, F_valid}, 32'd1);
  endtask

  task automatic consume;
    applyStimulus(1'b1, 1'b0, '0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0);
  endtask

  task automatic checkReset(input string tag);
    checkReq(tag, 32'h0000_3000);
    checkOutput({tag, "_pc4"}, pc4_F, 32'h0000_3004);
    checkOutput({tag, "_pc8"}, pc8_F, 32'h0000_3008);
  endtask

  task automatic resetDut;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    nextCycle();
    nextCycle();
    checkReset("reset");
    reset = 1'b0;
  endtask

  // Memory model: captures a request, answers memLat cycles later, drops on reset.
  initial begin
    imBus.im_rvalid = 1'b0;
    imBus.im_rdata  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        countdown       = 0;
        imBus.im_rvalid = 1'b0;
      end else begin
        imBus.im_rvalid = 1'b0;
        if (countdown > 0) begin
          countdown--;
          if (countdown == 0) begin
            checkOutput("rvalid_in_wait", {31'b0, imBus.im_req | F_valid}, 32'd0);
            imBus.im_rvalid = 1'b1;
            imBus.im_rdata  = memWord(reqAddr);
          end
        end
        if (imBus.im_req) begin
          checkOutput("single_outstanding", countdown, 32'd0);
          countdown = memLat;
          reqAddr   = imBus.im_addr;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    // Reset for two cycles, then the first request at RESET_PC.
    nextCycle();
    nextCycle();
    checkReset("t1_reset");
    memLat = 1;
    reset  = 1'b0;
    nextCycle();
    checkOutput("t1_wait_noreq", {31'b0, imBus.im_req}, 32'd0);
    checkOutput("t1_wait_valid", {31'b0, F_valid}, 32'd0);
    checkOutput("t1_wait_ir", IR_F, 32'h0);
    nextCycle();
    checkHold("t2_hold", 32'h2409_0001, 32'h0000_3000);

    // Stall in HOLD for five cycles.
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkHold("t3_stall", 32'h2409_0001, 32'h0000_3000);
    end
    consume();
    checkReq("t3_next", 32'h0000_3004);

    // Redirect during WAIT; delay slot delivered first, D_en bubble ignored.
    memLat = 3;
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h0000_3100);
    nextCycle();
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("t4_still_wait", {31'b0, F_valid}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("t4_bubble_noreq", {31'b0, imBus.im_req}, 32'd0);
    checkOutput("t4_bubble_valid", {31'b0, F_valid}, 32'd0);
    waitHold("t4", 8);
    checkHold("t4_slot", 32'h8C00_3004, 32'h0000_3004);
    memLat = 1;
    consume();
    checkReq("t4_tgt", 32'h0000_3100);
    waitHold("t4b", 8);
    checkHold("t4_tgtword", 32'h8C00_3100, 32'h0000_3100);
    consume();
    checkReq("t4_seq", 32'h0000_3104);

    // Redirect in the same cycle as HOLD&D_en, with unaligned low bits.
    resetDut();
    memLat = 1;
    nextCycle();
    nextCycle();
    checkHold("t5_first", 32'h2409_0001, 32'h0000_3000);
    consume();
    checkReq("t5_req3004", 32'h0000_3004);
    waitHold("t5", 8);
    checkHold("t5_slot", 32'h8C00_3004, 32'h0000_3004);
    applyStimulus(1'b1, 1'b1, 32'h0000_3103);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0);
    checkReq("t5_tgt", 32'h0000_3100);
    waitHold("t5b", 8);
    checkHold("t5_tgtword", 32'h8C00_3100, 32'h0000_3100);
    consume();
    checkReq("t5_after", 32'h0000_3104);

    // Two redirects during WAIT: the latest one wins.
    memLat = 2;
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h0000_4000);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h0000_5000);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0);
    waitHold("t7", 8);
    checkHold("t7_slot", 32'h8C00_3104, 32'h0000_3104);
    memLat = 1;
    consume();
    checkReq("t7_latest", 32'h0000_5000);
    waitHold("t7b", 8);
    checkHold("t7_word", 32'h8C00_5000, 32'h0000_5000);

    // Redirect in HOLD with D_en=0 is remembered; target wraps the PC adders.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0);
    checkHold("t8_kept", 32'h8C00_5000, 32'h0000_5000);
    consume();
    checkReq("t8_pend", 32'hFFFF_FFFC);
    waitHold("t8", 8);
    checkHold("t8_top", 32'h8C00_FFFC, 32'hFFFF_FFFC);
    checkOutput("t8_pc4_wrap", pc4_F, 32'h0000_0000);
    checkOutput("t8_pc8_wrap", pc8_F, 32'h0000_0004);
    consume();
    checkReq("t8_wrap", 32'h0000_0000);

    // Reset in WAIT with a pending redirect: it is discarded.
    memLat = 3;
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h0000_3200);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0);
    reset = 1'b1;
    nextCycle();
    nextCycle();
    checkReset("t6_reset");
    memLat = 1;
    reset  = 1'b0;
    nextCycle();
    nextCycle();
    checkHold("t6_first", 32'h2409_0001, 32'h0000_3000);
    consume();
    checkReq("t6_nopend", 32'h0000_3004);

    nextCycle();
    nextCycle();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fetch_unit_f.md
Name: fetch_unit_f

Overview:
F-stage instruction fetch unit. It drives the F-side inputs of the F/D pipeline register: IR_F, pc4_F and pc8_F.
- Owns the PC.
- Issues one fetch at a time to a variable-latency instruction memory.
- Holds the fetched word until the D register accepts it (D_en).
- Applies branch/jump redirects from D with MIPS delay-slot semantics: the instruction after the branch is always delivered before the target.

Parameters:
RESET_PC, 32'h0000_3000, address of the first fetch after reset
NOP_WORD, 32'h0000_0000, value driven on IR_F when no valid instruction is held

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
D_en  input  1  F/D register enable; 1 = D latches IR_F/pc4_F/pc8_F at this posedge
redirect_valid  input  1  D-stage taken branch/jump; next fetch after the delay slot goes to redirect_pc
redirect_pc  input  32  redirect target; bits [1:0] ignored
im_req  output  1  fetch request; one-cycle pulse, always accepted by memory
im_addr  output  32  word address of request, bits [1:0] = 00
im_rvalid  input  1  response valid; at most one response per request, ≥1 cycle after im_req
im_rdata  input  32  instruction word, valid when im_rvalid=1
IR_F  output  32  held instruction, or NOP_WORD when F_valid=0
pc4_F  output  32  PC of held instruction + 4
pc8_F  output  32  PC of held instruction + 8
F_valid  output  1  1 = IR_F holds a fetched instruction

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. Every register updates on posedge clk only.
- Registers: state, pc, ir_buf, pend_valid, pend_pc.
- FSM states: REQ, WAIT, HOLD.
- REQ: im_req=1, im_addr=pc. Next state is WAIT.
- WAIT: im_req=0. On im_rvalid: ir_buf<=im_rdata, state<=HOLD. Otherwise stay in WAIT.
- HOLD: F_valid=1, IR_F=ir_buf, pc4_F=pc+4, pc8_F=pc+8.
  - D_en=0: stay in HOLD; all outputs stable; im_req=0.
  - D_en=1: state<=REQ; pc<=next_pc; pend_valid<=0.
- next_pc priority:
  - redirect_valid=1 → {redirect_pc[31:2],2'b00}
  - else pend_valid=1 → pend_pc
  - else pc+4
- Redirect not consumed in the same cycle (any state, or HOLD with D_en=0): pend_valid<=1, pend_pc<={redirect_pc[31:2],2'b00}. If it repeats, the latest value wins.
- Delay slot: a redirect never cancels the fetch in progress or the held word. That word is delivered next, then the target.
- When F_valid=0 (states REQ and WAIT): IR_F=NOP_WORD, pc4_F=pc+4, pc8_F=pc+8. D_en=1 in these states inserts a bubble in D and does not change fetch state.
- Outputs are pure functions of registers; no combinational path from inputs to outputs.
- Latency:
  - Minimum 3 cycles per instruction with 1-cycle memory: REQ, WAIT with rvalid, HOLD with D_en.
  - First request issues in the first cycle after reset deasserts.
- Arithmetic: pc+4 and pc+8 wrap modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000).
- Reset values:
  - state=REQ, pc=RESET_PC, ir_buf=0, pend_valid=0, pend_pc=0.
  - Outputs: im_req=1, im_addr=RESET_PC, F_valid=0, IR_F=NOP_WORD, pc4_F=RESET_PC+4, pc8_F=RESET_PC+8.
- Reset mid-operation: an outstanding request is abandoned and pending redirects are cleared. The memory shares reset and drops its in-flight response.
- im_rvalid outside WAIT is a protocol violation. It is ignored, and the bench asserts it never occurs.

Decomposition:
- Shared package: RESET_PC and NOP_WORD constants, FSM state encoding (REQ/WAIT/HOLD), and the 32-bit word type.
- No sub-module required; next_pc selection stays inline.

Test Plan:
1. Reset for 2 cycles, then release → first cycle: im_req=1, im_addr=0x3000, F_valid=0, IR_F=0; no other request until a response arrives.
2. 1-cycle memory returning 0x2409_0001 at 0x3000, D_en=1 → HOLD: IR_F=0x2409_0001, pc4_F=0x3004, pc8_F=0x3008; next im_addr=0x3004.
3. HOLD with D_en=0 for 5 cycles → IR_F/pc4_F/pc8_F/F_valid unchanged, im_req=0 throughout; D_en=1 → next im_addr=0x3004.
4. redirect_valid pulse with redirect_pc=0x3100 while in WAIT for 0x3004 → 0x3004 delivered (pc4_F=0x3008), then im_addr=0x3100, pend_valid cleared.
5. redirect_pc=0x3103 in the same cycle as HOLD&D_en at pc=0x3004 → next im_addr=0x3100; a later consume fetches 0x3104.
6. Reset asserted in WAIT with a pending redirect to 0x3200 → im_addr=0x3000 after reset, pend_valid=0, no fetch at 0x3200.
